// File: rtl/proximity_monitor.sv
// Multi-channel proximity monitor: per-channel latched distance with hysteretic,
// debounced warning zones, a registered nearest-obstacle report and a parking beep.
module proximity_monitor #(
   parameter int CHANNELS   = 4,
   parameter int DIST_W     = 5,
   parameter int ZONE_NEAR  = 20,
   parameter int ZONE_CLOSE = 10,
   parameter int ZONE_CRIT  = 5,
   parameter int HYST       = 1,
   parameter int DEBOUNCE   = 2,
   parameter int BEEP_BASE  = 8,
   localparam int CH_W      = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [CHANNELS-1:0]          ch_active,
   input  logic                         sample_valid,
   input  logic [CH_W-1:0]              sample_ch,
   input  logic [DIST_W-1:0]            distance,
   output logic [CHANNELS*DIST_W-1:0]   ch_distance,
   output logic [CHANNELS*2-1:0]        ch_zone,
   output logic [CH_W-1:0]              nearest_ch,
   output logic [DIST_W-1:0]            nearest_distance,
   output logic                         any_active,
   output logic                         beep
);

   typedef enum logic [1:0] {Z_FAR = 2'd0, Z_NEAR = 2'd1, Z_CLOSE = 2'd2, Z_CRIT = 2'd3} zone_t;

   localparam int BCW = $clog2(4*BEEP_BASE) + 1;

   logic [DIST_W-1:0] dist_q [CHANNELS];
   logic [DIST_W-1:0] dist_d [CHANNELS];
   zone_t             zone_q [CHANNELS];
   zone_t             zone_d [CHANNELS];
   zone_t             cand_q [CHANNELS];
   zone_t             cand_d [CHANNELS];
   logic [2:0]        cnt_q  [CHANNELS];
   logic [2:0]        cnt_d  [CHANNELS];

   logic              accept;
   zone_t             z_post;

   logic [CH_W-1:0]   nearest_ch_q, nearest_ch_d;
   logic [DIST_W-1:0] nearest_dist_q, nearest_dist_d;
   logic              any_q, any_d;
   zone_t             worst_q, worst_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic              beep_q, beep_d;
   int                half;

   function automatic int upper_bound(input zone_t z);
      case (z)
         Z_NEAR:  return ZONE_NEAR;
         Z_CLOSE: return ZONE_CLOSE;
         Z_CRIT:  return ZONE_CRIT;
         default: return 1 << DIST_W;
      endcase
   endfunction

   // A reading of 0 means nothing in range, so it is not held back by hysteresis.
   function automatic zone_t post_zone(input logic [DIST_W-1:0] d, input zone_t cur);
      zone_t raw;
      int    di;
      di = int'(d);
      if (di == 0 || di > ZONE_NEAR)  raw = Z_FAR;
      else if (di > ZONE_CLOSE)       raw = Z_NEAR;
      else if (di > ZONE_CRIT)        raw = Z_CLOSE;
      else                            raw = Z_CRIT;
      if (raw < cur && di != 0 && di <= upper_bound(cur) + HYST) return cur;
      return raw;
   endfunction

   always_comb begin
      accept = sample_valid && (int'(sample_ch) < CHANNELS) && ch_active[sample_ch];
      z_post = post_zone(distance, zone_q[sample_ch]);
      for (int i = 0; i < CHANNELS; i++) begin
         dist_d[i] = dist_q[i];
         zone_d[i] = zone_q[i];
         cand_d[i] = cand_q[i];
         cnt_d[i]  = cnt_q[i];
         if (!ch_active[i]) begin
            dist_d[i] = '0;
            zone_d[i] = Z_FAR;
            cand_d[i] = Z_FAR;
            cnt_d[i]  = '0;
         end else if (accept && int'(sample_ch) == i) begin
            dist_d[i] = distance;
            if (z_post == Z_CRIT || z_post == zone_q[i]) begin
               zone_d[i] = z_post;
               cand_d[i] = Z_FAR;
               cnt_d[i]  = '0;
            end else if (z_post == cand_q[i] && cnt_q[i] != 3'd0) begin
               if (int'(cnt_q[i]) + 1 >= DEBOUNCE) begin
                  zone_d[i] = z_post;
                  cand_d[i] = Z_FAR;
                  cnt_d[i]  = '0;
               end else begin
                  cnt_d[i]  = cnt_q[i] + 3'd1;
               end
            end else if (DEBOUNCE <= 1) begin
               zone_d[i] = z_post;
               cand_d[i] = Z_FAR;
               cnt_d[i]  = '0;
            end else begin
               cand_d[i] = z_post;
               cnt_d[i]  = 3'd1;
            end
         end
      end
   end

   // Nearest-obstacle search and worst zone; strict '<' keeps the lowest index on ties.
   always_comb begin
      nearest_ch_d   = '0;
      nearest_dist_d = '0;
      any_d          = 1'b0;
      worst_d        = Z_FAR;
      for (int i = 0; i < CHANNELS; i++) begin
         if (zone_q[i] != Z_FAR) begin
            if (!any_d || dist_q[i] < nearest_dist_d) begin
               any_d          = 1'b1;
               nearest_ch_d   = CH_W'(i);
               nearest_dist_d = dist_q[i];
            end
            if (zone_q[i] > worst_d) worst_d = zone_q[i];
         end
      end
   end

   always_comb begin
      half   = (worst_q == Z_NEAR) ? 2*BEEP_BASE : BEEP_BASE;
      bcnt_d = '0;
      beep_d = 1'b0;
      if (worst_d != worst_q) begin
         beep_d = (worst_d != Z_FAR);
      end else if (worst_q == Z_CRIT) begin
         beep_d = 1'b1;
      end else if (worst_q != Z_FAR) begin
         bcnt_d = (int'(bcnt_q) == 2*half - 1) ? '0 : bcnt_q + BCW'(1);
         beep_d = int'(bcnt_d) < half;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < CHANNELS; i++) begin
            dist_q[i] <= '0;
            zone_q[i] <= Z_FAR;
            cand_q[i] <= Z_FAR;
            cnt_q[i]  <= '0;
         end
         nearest_ch_q   <= '0;
         nearest_dist_q <= '0;
         any_q          <= 1'b0;
         worst_q        <= Z_FAR;
         bcnt_q         <= '0;
         beep_q         <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            dist_q[i] <= dist_d[i];
            zone_q[i] <= zone_d[i];
            cand_q[i] <= cand_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         nearest_ch_q   <= nearest_ch_d;
         nearest_dist_q <= nearest_dist_d;
         any_q          <= any_d;
         worst_q        <= worst_d;
         bcnt_q         <= bcnt_d;
         beep_q         <= beep_d;
      end
   end

   always_comb begin
      ch_distance = '0;
      ch_zone     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ch_distance[i*DIST_W +: DIST_W] = dist_q[i];
         ch_zone[i*2 +: 2]               = zone_q[i];
      end
   end

   assign nearest_ch       = nearest_ch_q;
   assign nearest_distance = nearest_dist_q;
   assign any_active       = any_q;
   assign beep             = beep_q;

endmodule
